// File: rtl/microstate_sequencer.sv
// Control-unit microsequencer: fetch/decode, then the execute micro-sequence for the
// entry state chosen by the instruction encoder, with a bounded wait on memory completion.
module microstate_sequencer #(
    parameter int STATE_W     = 8,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] entry_state,
    input  logic               cond_true,
    input  logic               is_load,
    input  logic [15:0]        reg_list,
    input  logic               moc,
    output logic [STATE_W-1:0] state,
    output logic               mar_ld,
    output logic               pc_ld,
    output logic               ir_ld,
    output logic               rf_ld,
    output logic               mem_en,
    output logic               mem_rw,
    output logic               illegal,
    output logic               mem_fault,
    output logic [4:0]         xfer_left
);

    localparam int TMO_W = (MOC_TIMEOUT < 2) ? 1 : $clog2(MOC_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOC_TIMEOUT - 1);

    typedef enum logic [STATE_W-1:0] {
        ST_RESET   = STATE_W'(0),
        ST_FETCH0  = STATE_W'(1),
        ST_FETCH1  = STATE_W'(2),
        ST_FETCH2  = STATE_W'(3),
        ST_DECODE  = STATE_W'(4),
        ST_MEMWAIT = STATE_W'(120),
        ST_WB      = STATE_W'(121),
        ST_BLPC    = STATE_W'(122),
        ST_MXFER   = STATE_W'(124),
        ST_MNEXT   = STATE_W'(125)
    } ustate_t;

    typedef enum logic [2:0] {G_NONE, G_DP, G_LS, G_B, G_BL, G_MUL} grp_t;

    function automatic grp_t group_of(input logic [STATE_W-1:0] s);
        int v;
        v = int'(s);
        if (v == 5 || v == 6 || v == 10 || v == 11 || (v >= 39 && v <= 64) || (v >= 81 && v <= 108))
            return G_DP;
        if (v >= 25 && v <= 36) return G_LS;
        if (v == 37) return G_B;
        if (v == 38) return G_BL;
        if (v >= 65 && v <= 80) return G_MUL;
        return G_NONE;
    endfunction

    logic [STATE_W-1:0] state_reg, state_next;
    logic [4:0]         xfer_reg, xfer_next;
    logic               load_reg, load_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;

    logic [15:0] pair_flat;
    logic [4:0]  pop_cnt;
    logic [4:0]  xfer_dec;
    logic        tmo_expire;

    // Two-bit partial sums per register pair, then an 8-term sum: 16 fits in 5 bits.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pair
        assign pair_flat[2*gi +: 2] = {1'b0, reg_list[2*gi]} + {1'b0, reg_list[2*gi+1]};
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < 8; i++) pop_cnt = pop_cnt + {3'd0, pair_flat[2*i +: 2]};
    end

    assign xfer_dec   = (xfer_reg != 5'd0) ? xfer_reg - 5'd1 : 5'd0;
    assign tmo_expire = (tmo_reg == TMO_LAST);
    assign state      = state_reg;
    assign xfer_left  = xfer_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RESET;
            xfer_reg  <= '0;
            load_reg  <= 1'b0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            xfer_reg  <= xfer_next;
            load_reg  <= load_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        xfer_next  = xfer_reg;
        load_next  = load_reg;
        tmo_next   = '0;
        mar_ld     = 1'b0;
        pc_ld      = 1'b0;
        ir_ld      = 1'b0;
        rf_ld      = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        illegal    = 1'b0;
        mem_fault  = 1'b0;
        case (state_reg)
            ST_RESET:  state_next = ST_FETCH0;
            ST_FETCH0: begin mar_ld = 1'b1; state_next = ST_FETCH1; end
            ST_FETCH1: begin pc_ld = 1'b1; state_next = ST_FETCH2; end
            ST_FETCH2: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (moc) begin
                    ir_ld      = 1'b1;
                    state_next = ST_DECODE;
                end else if (tmo_expire) begin
                    mem_fault  = 1'b1;
                    state_next = ST_FETCH0;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_DECODE: begin
                if (!cond_true) begin
                    state_next = ST_FETCH0;
                end else if (group_of(entry_state) == G_NONE) begin
                    illegal    = 1'b1;
                    state_next = ST_FETCH0;
                end else begin
                    state_next = entry_state;
                end
            end
            ST_MEMWAIT: begin
                mem_en = 1'b1;
                mem_rw = load_reg;
                if (moc) begin
                    state_next = ST_WB;
                end else if (tmo_expire) begin
                    mem_fault  = 1'b1;
                    state_next = ST_FETCH0;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_WB:   begin rf_ld = 1'b1; state_next = ST_FETCH0; end
            ST_BLPC: begin pc_ld = 1'b1; state_next = ST_FETCH0; end
            ST_MXFER: begin
                mem_en = 1'b1;
                mem_rw = load_reg;
                if (moc) begin
                    rf_ld      = load_reg;
                    xfer_next  = xfer_dec;
                    state_next = (xfer_dec == 5'd0) ? ST_FETCH0 : ST_MNEXT;
                end else if (tmo_expire) begin
                    // An aborted block transfer leaves nothing pending.
                    mem_fault  = 1'b1;
                    xfer_next  = 5'd0;
                    state_next = ST_FETCH0;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_MNEXT: begin mar_ld = 1'b1; state_next = ST_MXFER; end
            default: begin
                // Execute entry states are numbered by the encoder, decoded here by range.
                case (group_of(state_reg))
                    G_DP: begin rf_ld = 1'b1; state_next = ST_FETCH0; end
                    G_LS: begin
                        mar_ld     = 1'b1;
                        load_next  = is_load;
                        state_next = ST_MEMWAIT;
                    end
                    G_B:  begin pc_ld = 1'b1; state_next = ST_FETCH0; end
                    G_BL: begin rf_ld = 1'b1; state_next = ST_BLPC; end
                    G_MUL: begin
                        mar_ld     = 1'b1;
                        load_next  = is_load;
                        xfer_next  = pop_cnt;
                        state_next = (pop_cnt == 5'd0) ? ST_FETCH0 : ST_MXFER;
                    end
                    default: begin illegal = 1'b1; state_next = ST_FETCH0; end
                endcase
            end
        endcase
    end

endmodule
